// File: rtl/fifo_word_packer.sv
// fifo_word_packer: packs PACK_RATIO narrow words popped from a FWFT FIFO
// into one wide word on a registered valid/ready output stream.
// Lane 0 (LSBs) holds the first popped word.
// Optional feature: define PACKER_FLUSH_EN to enable flush_i, which emits a
// partially filled word with out_keep_o giving the number of filled lanes.

// One collect lane: holds a single narrow word until the wide word is built.
module fifo_word_packer_lane #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          ld,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    // Capture the popped word when this lane is the one being filled
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            q <= '0;
        else if (ld)
            q <= d;
    end
endmodule

module fifo_word_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int PACK_RATIO = 4,
    localparam int KW = $clog2(PACK_RATIO + 1),
    localparam int OW = DATA_WIDTH * PACK_RATIO
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  fifo_read_o,
    input  logic                  flush_i,
    output logic [OW-1:0]         out_data_o,
    output logic [KW-1:0]         out_keep_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
);
    localparam int CW = $clog2(PACK_RATIO);
    localparam int NL = PACK_RATIO - 1;

    logic [CW-1:0]                cnt;
    logic [NL-1:0][DATA_WIDTH-1:0] coll;
    logic                         out_free;
    logic                         last;
    logic                         pop;
    logic                         flush_pend;
    logic                         do_flush;

    assign out_free = !out_valid_o | out_ready_i;
    assign last     = (cnt == CW'(PACK_RATIO - 1));

`ifdef PACKER_FLUSH_EN
    logic [NL-1:0][DATA_WIDTH-1:0] flush_lanes;

    // A flush (fresh or pending) with a non-empty collection drains once the
    // output register is free; an empty collection never produces a word.
    assign do_flush = (flush_i | flush_pend) & (cnt != '0) & out_free;

    // Only the final-lane pop waits on the output; flush blocks all pops.
    assign pop = rst_n_i & !fifo_empty_i & !flush_i & !flush_pend &
                 !(last & !out_free);

    // Zero the lanes that were never filled so stale data does not leak out
    always_comb begin
        flush_lanes = '0;
        for (int k = 0; k < NL; k++)
            if (CW'(k) < cnt)
                flush_lanes[k] = coll[k];
    end

    // Remember a flush that arrived while the output was stalled
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            flush_pend <= 1'b0;
        else if (do_flush)
            flush_pend <= 1'b0;
        else if (flush_i & (cnt != '0) & !out_free)
            flush_pend <= 1'b1;
    end
`else
    logic unused_flush;

    assign unused_flush = flush_i;
    assign flush_pend   = 1'b0;
    assign do_flush     = 1'b0;
    assign pop          = rst_n_i & !fifo_empty_i & !(last & !out_free);
`endif

    assign fifo_read_o = pop;

    // Collect lanes 0..PACK_RATIO-2; the final lane goes straight to the output
    for (genvar k = 0; k < NL; k++) begin : g_lane
        fifo_word_packer_lane #(.DW(DATA_WIDTH)) u_lane (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .ld      (pop & (cnt == CW'(k))),
            .d       (fifo_rd_data_i),
            .q       (coll[k])
        );
    end

    // Lane counter: advances per pop, wraps after the final lane or a flush
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt <= '0;
        else if (pop)
            cnt <= last ? '0 : cnt + 1'b1;
        else if (do_flush)
            cnt <= '0;
    end

    // Output register: load on final-lane pop or flush, clear valid on accept
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_data_o  <= '0;
            out_keep_o  <= '0;
            out_valid_o <= 1'b0;
        end else if (pop & last) begin
            out_data_o  <= {fifo_rd_data_i, coll};
            out_keep_o  <= KW'(PACK_RATIO);
            out_valid_o <= 1'b1;
`ifdef PACKER_FLUSH_EN
        end else if (do_flush) begin
            out_data_o  <= {{DATA_WIDTH{1'b0}}, flush_lanes};
            out_keep_o  <= KW'(cnt);
            out_valid_o <= 1'b1;
`endif
        end else if (out_valid_o & out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (DATA_WIDTH=8, PACK_RATIO=4) with a
// queue-based FWFT FIFO model feeding the DUT. Flush scenarios are built
// when PACKER_FLUSH_EN is defined; otherwise flush_i is checked as ignored.
module tb_fifo_word_packer;
    localparam int DW = 8;
    localparam int PR = 4;
    localparam int KW = 3;

    logic          clk;
    logic          rst_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_read;
    logic          flush;
    logic [31:0]   out_data;
    logic [KW-1:0] out_keep;
    logic          out_valid;
    logic          out_ready;

    logic [DW-1:0] fq[$];
    logic          last_rd;
    int            tot;
    int            bad;

    fifo_word_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .fifo_empty_i   (fifo_empty),
        .fifo_rd_data_i (fifo_rd_data),
        .fifo_read_o    (fifo_read),
        .flush_i        (flush),
        .out_data_o     (out_data),
        .out_keep_o     (out_keep),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh();
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = (fq.size() > 0) ? fq[0] : 8'h00;
    endtask

    task automatic push(input logic [DW-1:0] v);
        fq.push_back(v);
        refresh();
    endtask

    // One clock: sample pop request mid-cycle, then retire it from the model
    task automatic cycle();
        logic [DW-1:0] t;
        @(negedge clk);
        last_rd = fifo_read;
        @(posedge clk);
        #1;
        if (last_rd && fq.size() > 0) t = fq.pop_front();
        refresh();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1; flush = 1'b0;
        refresh();
        #3;
        tot++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        tot++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 00000000", out_data); end
        tot++; if (out_keep !== 3'd0) begin bad++; $display("FAIL rst_keep: got %0d want 0", out_keep); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        // build a held word plus two collected lanes, then reset
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) push(8'(i));
        repeat (6) cycle();
        tot++; if (out_data !== 32'h04030201 || out_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_word: got %h/%b want 04030201/1", out_data, out_valid); end
        rst_n = 1'b0;
        #1;
        tot++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        tot++; if (out_data !== 32'h0) begin bad++; $display("FAIL midrst_data: got %h want 00000000", out_data); end
        tot++; if (out_keep !== 3'd0) begin bad++; $display("FAIL midrst_keep: got %0d want 0", out_keep); end
        tot++; if (fifo_read !== 1'b0) begin bad++; $display("FAIL midrst_read: got %b want 0", fifo_read); end
        fq.delete(); refresh(); out_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        begin
            int n, at;
            logic [31:0] d;
            logic [KW-1:0] k;
            n = 0; at = 0; d = '0; k = '0;
            push(8'h11); push(8'h22); push(8'h33); push(8'h44);
            for (int i = 1; i <= 8; i++) begin
                cycle();
                if (out_valid) begin n++; at = i; d = out_data; k = out_keep; end
            end
            tot++; if (n !== 1) begin bad++; $display("FAIL post_rst_count: got %0d want 1", n); end
            tot++; if (d !== 32'h44332211) begin bad++; $display("FAIL post_rst_data: got %h want 44332211", d); end
            tot++; if (k !== 3'd4) begin bad++; $display("FAIL post_rst_keep: got %0d want 4", k); end
            tot++; if (at !== 4) begin bad++; $display("FAIL post_rst_latency: got %0d want 4", at); end
        end
    endtask

    task automatic test_streaming();
        logic [9:0]  rd_mask;
        int          nv, i1, i2;
        logic [31:0] d1, d2;
        rd_mask = '0; nv = 0; i1 = 0; i2 = 0; d1 = '0; d2 = '0;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        for (int i = 1; i <= 10; i++) begin
            cycle();
            rd_mask[i-1] = last_rd;
            if (out_valid) begin
                nv++;
                if (nv == 1) begin i1 = i; d1 = out_data; end
                else begin i2 = i; d2 = out_data; end
            end
        end
        tot++; if (rd_mask !== 10'b0011111111) begin bad++; $display("FAIL stream_reads: got %b want 0011111111", rd_mask); end
        tot++; if (nv !== 2) begin bad++; $display("FAIL stream_count: got %0d want 2", nv); end
        tot++; if (d1 !== 32'h04030201 || i1 !== 4) begin bad++; $display("FAIL stream_first: got %h@%0d want 04030201@4", d1, i1); end
        tot++; if (d2 !== 32'h08070605 || i2 !== 8) begin bad++; $display("FAIL stream_second: got %h@%0d want 08070605@8", d2, i2); end
    endtask

    task automatic test_backpressure();
        int nrd;
        nrd = 0;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (4) cycle();
        tot++; if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin bad++; $display("FAIL bp_first: got %h/%b want 04030201/1", out_data, out_valid); end
        out_ready = 1'b0;
        repeat (6) begin cycle(); nrd += int'(last_rd); end
        tot++; if (nrd !== 3) begin bad++; $display("FAIL bp_pops: got %0d want 3", nrd); end
        tot++; if (fifo_read !== 1'b0) begin bad++; $display("FAIL bp_read_held: got %b want 0", fifo_read); end
        tot++; if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin bad++; $display("FAIL bp_hold: got %h/%b want 04030201/1", out_data, out_valid); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        tot++; if (last_rd !== 1'b1) begin bad++; $display("FAIL bp_final_pop: got %b want 1", last_rd); end
        tot++; if (out_valid !== 1'b1 || out_data !== 32'h08070605 || out_keep !== 3'd4) begin bad++; $display("FAIL bp_b2b: got %h/%b/%0d want 08070605/1/4", out_data, out_valid, out_keep); end
        out_ready = 1'b1;
        cycle();
        tot++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_empty_stall();
        int nrd, gap_rd, nv;
        logic got;
        nrd = 0; gap_rd = 0; nv = 0; got = 1'b0;
        out_ready = 1'b1;
        push(8'hAA); push(8'hBB);
        repeat (2) begin cycle(); nrd += int'(last_rd); end
        repeat (10) begin cycle(); gap_rd += int'(last_rd); nv += int'(out_valid); end
        tot++; if (nrd !== 2) begin bad++; $display("FAIL stall_first_pops: got %0d want 2", nrd); end
        tot++; if (gap_rd !== 0 || nv !== 0) begin bad++; $display("FAIL stall_gap: got reads=%0d valids=%0d want 0/0", gap_rd, nv); end
        push(8'hCC); push(8'hDD);
        for (int i = 0; i < 6 && !got; i++) begin cycle(); got = out_valid; end
        tot++; if (got !== 1'b1 || out_data !== 32'hDDCCBBAA || out_keep !== 3'd4) begin bad++; $display("FAIL stall_word: got %b/%h/%0d want 1/DDCCBBAA/4", got, out_data, out_keep); end
        cycle();
    endtask

`ifdef PACKER_FLUSH_EN
    task automatic test_flush();
        logic got;
        got = 1'b0;
        out_ready = 1'b1;
        push(8'h11); push(8'h22);
        repeat (2) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        tot++; if (out_valid !== 1'b1 || out_data !== 32'h00002211 || out_keep !== 3'd2) begin bad++; $display("FAIL flush_word: got %b/%h/%0d want 1/00002211/2", out_valid, out_data, out_keep); end
        cycle();
        push(8'h55);
        flush = 1'b1;
        #1;
        tot++; if (fifo_read !== 1'b0) begin bad++; $display("FAIL flush0_inhibit: got %b want 0", fifo_read); end
        cycle();
        flush = 1'b0;
        tot++; if (out_valid !== 1'b0 || fq.size() !== 1) begin bad++; $display("FAIL flush0_noop: got valid=%b q=%0d want 0/1", out_valid, fq.size()); end
        push(8'h66); push(8'h77); push(8'h88);
        for (int i = 0; i < 8 && !got; i++) begin cycle(); got = out_valid; end
        tot++; if (got !== 1'b1 || out_data !== 32'h88776655 || out_keep !== 3'd4) begin bad++; $display("FAIL flush_after: got %b/%h/%0d want 1/88776655/4", got, out_data, out_keep); end
        cycle();
    endtask

    task automatic test_pending_flush();
        int nrd;
        logic got;
        nrd = 0; got = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (8) cycle();
        tot++; if (out_data !== 32'h04030201 || fifo_read !== 1'b0) begin bad++; $display("FAIL pend_setup: got %h/rd=%b want 04030201/0", out_data, fifo_read); end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        nrd += int'(last_rd);
        repeat (2) begin cycle(); nrd += int'(last_rd); end
        tot++; if (nrd !== 0 || out_data !== 32'h04030201) begin bad++; $display("FAIL pend_hold: got pops=%0d data=%h want 0/04030201", nrd, out_data); end
        out_ready = 1'b1;
        #1;
        tot++; if (fifo_read !== 1'b0) begin bad++; $display("FAIL pend_inhibit: got %b want 0", fifo_read); end
        cycle();
        tot++; if (out_valid !== 1'b1 || out_data !== 32'h00070605 || out_keep !== 3'd3) begin bad++; $display("FAIL pend_word: got %b/%h/%0d want 1/00070605/3", out_valid, out_data, out_keep); end
        push(8'h09); push(8'h0A); push(8'h0B);
        for (int i = 0; i < 8 && !got; i++) begin cycle(); got = out_valid; end
        tot++; if (got !== 1'b1 || out_data !== 32'h0B0A0908 || out_keep !== 3'd4) begin bad++; $display("FAIL pend_after: got %b/%h/%0d want 1/0B0A0908/4", got, out_data, out_keep); end
        cycle();
    endtask
`else
    task automatic test_flush_ignored();
        out_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        flush = 1'b1;
        #1;
        tot++; if (fifo_read !== 1'b1) begin bad++; $display("FAIL noflush_read: got %b want 1", fifo_read); end
        cycle();
        flush = 1'b0;
        repeat (3) cycle();
        tot++; if (out_valid !== 1'b1 || out_data !== 32'h44332211 || out_keep !== 3'd4) begin bad++; $display("FAIL noflush_word: got %b/%h/%0d want 1/44332211/4", out_valid, out_data, out_keep); end
        cycle();
    endtask
`endif

    initial begin
        tot = 0; bad = 0; last_rd = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_stall();
`ifdef PACKER_FLUSH_EN
        test_flush();
        test_pending_flush();
`else
        test_flush_ignored();
`endif
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Width up-converter downstream of the synchronous FWFT FIFO buffer. It pops DATA_WIDTH words from the FIFO read port and packs PACK_RATIO consecutive words into one wide word. The wide word is presented on a registered valid/ready output stream, so the narrow FIFO side can feed a wide datapath such as a bus master or DMA write port at full rate.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one FIFO word.
- PACK_RATIO, 4, FIFO words per output word; must be ≥2. Output width OW = DATA_WIDTH*PACK_RATIO.
- KW (localparam), $clog2(PACK_RATIO+1), width of out_keep_o.

Ports:
- clk_i  in  1  single clock, all logic on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rd_data_i  in  DATA_WIDTH  FIFO head word; valid whenever fifo_empty_i=0 (FWFT).
- fifo_read_o  out  1  pop request; combinational; never asserted while fifo_empty_i=1.
- flush_i  in  1  single-cycle request to emit a partially filled word (see Configuration).
- out_data_o  out  OW  packed word; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_keep_o  out  KW  number of valid lanes in out_data_o (1..PACK_RATIO).
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  consumer accepts the word when valid and ready are both high at a rising edge.

## Operation
- State:
  - collect register coll (PACK_RATIO-1 lanes);
  - lane counter cnt (0..PACK_RATIO-1);
  - output register (out_data_o, out_keep_o, out_valid_o);
  - flush_pend flag.
- Lane order: first popped word goes to lane 0, which is the LSBs.
- out_free = !out_valid_o | out_ready_i.
- pop = !fifo_empty_i & !flush_i & !flush_pend & !(cnt==PACK_RATIO-1 & !out_free).
- fifo_read_o = pop.
- Pop with cnt<PACK_RATIO-1:
  - coll lane cnt <= fifo_rd_data_i;
  - cnt <= cnt+1.
- Pop with cnt==PACK_RATIO-1:
  - out_data_o <= {fifo_rd_data_i, coll};
  - out_keep_o <= PACK_RATIO;
  - out_valid_o <= 1;
  - cnt <= 0.
- Output handshake:
  - When out_valid_o & out_ready_i and no new load occurs, out_valid_o <= 0.
  - out_data_o and out_keep_o hold their last value.
  - A load and an accept in the same cycle are back-to-back: out_valid_o stays 1 with the new data.
- out_data_o, out_keep_o and out_valid_o stay stable while out_valid_o=1 & out_ready_i=0.
- cnt wraps from PACK_RATIO-1 to 0; there is no other wrap.
- A FIFO empty in mid-collection stalls collection; coll and cnt are held indefinitely.

## Timing
- Reset, asynchronous, while rst_n_i=0:
  - out_valid_o=0, out_data_o=0, out_keep_o=0;
  - cnt=0, coll=0, flush_pend=0;
  - fifo_read_o=0 (gated with the reset).
- Reset asserted mid-collection or mid-handshake discards any partial or pending word.
- Latency: the pop of the final lane at edge N gives out_valid_o=1 after edge N.
- Throughput: one pop per cycle while the FIFO is non-empty and the output drains each cycle, i.e. one output word every PACK_RATIO cycles with no bubbles.
- Backpressure: pops continue into lanes 0..PACK_RATIO-2 while the output is stalled. Only the final-lane pop waits for out_free.

## Configuration
- Macro PACKER_FLUSH_EN.
- Defined:
  - flush_i high for one cycle with cnt>0 inhibits the pop that cycle.
  - If out_free: out_data_o <= coll with unfilled lanes zeroed, out_keep_o <= cnt, out_valid_o <= 1, cnt <= 0.
  - If not out_free: flush_pend <= 1 and pops are inhibited. The same transfer occurs on the first cycle out_free=1, then flush_pend <= 0.
  - flush_i with cnt==0 is a no-op (no empty word is emitted), but it still inhibits the pop that cycle.
- Not defined:
  - flush_i is ignored and removed from the pop equation.
  - flush_pend is constant 0.
  - out_keep_o = PACK_RATIO whenever out_valid_o=1.

## Test plan
Test configuration: DATA_WIDTH=8, PACK_RATIO=4, out_ready_i=1 unless stated.
- Reset: assert rst_n_i=0 mid-collection with cnt=2 → outputs zero immediately. After release, the FIFO words 0x11,0x22,0x33,0x44 give a single out_data_o=0x44332211 with keep=4.
- Streaming: FIFO preloaded with 0x01..0x08 → fifo_read_o high 8 consecutive cycles. Outputs 0x04030201 then 0x08070605, the second exactly 4 cycles after the first.
- Backpressure: out_ready_i=0 after the first output, with 0x01..0x08 in the FIFO → exactly 3 further pops, then fifo_read_o=0 with output held at 0x04030201. Raising ready for 1 cycle gives 0x08070605 on the next cycle.
- Empty stall: FIFO gives 0xAA,0xBB, then is empty for 10 cycles, then gives 0xCC,0xDD → fifo_read_o=0 during the gap and one output 0xDDCCBBAA.
- Flush (PACKER_FLUSH_EN): after 0x11,0x22 pulse flush_i → out_data_o=0x00002211, keep=2. A repeat flush with cnt=0 gives no output.
- Pending flush (PACKER_FLUSH_EN): output stalled with ready=0 holding a full word and cnt=3, pulse flush_i → no pops. One cycle after ready rises, the partial word appears with keep=3.
